rob_ctrl: RTL and testbench
===========================

# rob_ctrl

Sequencing controller for the reorder buffer: owns the head/tail pointers, grants all-or-nothing allocation of up to ISSUE_WIDTH entries per cycle to the rename stage, and records writeback completion. It retires completed entries in order, up to COMMIT_WIDTH per cycle. On a branch mispredict it walks the squashed entries back one per cycle, youngest first, so the rename table can be rolled back. It sits between rename/dispatch, the execution writeback ports and the architectural commit logic.

## Interface
- ROB_SIZE, 8, entry count; power of two, at least 4; IDX_W = log2(ROB_SIZE)
- ISSUE_WIDTH, 4, maximum allocations per cycle; must not exceed ROB_SIZE
- COMMIT_WIDTH, 2, maximum retirements per cycle
- WB_PORTS, 2, completion ports
- Reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_req  in  1  rename requests allocation
- alloc_cnt  in  clog2(ISSUE_WIDTH+1)  entries requested; 0 means no request
- alloc_has_dst  in  ISSUE_WIDTH  lane i writes a destination register
- alloc_dst  in  ISSUE_WIDTH*5  destination architectural register per lane
- alloc_gnt  out  1  allocation accepted this cycle
- alloc_idx  out  ISSUE_WIDTH*IDX_W  lane i gets entry (tail+i) mod ROB_SIZE
- wb_valid  in  WB_PORTS  completion strobe
- wb_idx  in  WB_PORTS*IDX_W  completed entry
- commit_stall  in  1  commit consumer not ready
- commit_valid  out  COMMIT_WIDTH  lane retires this cycle
- commit_idx, commit_has_dst, commit_dst  out  per lane  retiring entry and its destination
- flush_req  in  1  mispredict at entry flush_idx; all younger entries are squashed
- flush_idx  in  IDX_W  mispredicting entry
- rb_valid, rb_idx, rb_has_dst, rb_dst  out  1/IDX_W/1/5  rollback of one squashed entry
- count  out  IDX_W+1  occupied entries
- full, empty, busy  out  1  count==ROB_SIZE, count==0, state==RECOVER

## Operation
- Pointers: head and tail are IDX_W+1 bits wide, and wrap naturally. count = tail − head. Each entry holds valid, done, has_dst and dst.
- FSM states: RUN and RECOVER. Reset enters RUN.
- Allocation:
  - alloc_gnt = RUN & alloc_req & alloc_cnt≠0 & alloc_cnt ≤ ROB_SIZE−count & !flush_req.
  - The free-space check uses the registered count; same-cycle commits are not credited.
  - On grant, lanes 0..alloc_cnt−1 are written valid=1, done=0, and tail += alloc_cnt. Lanes ≥ alloc_cnt are ignored.
- Writeback: sets done for a valid entry. A writeback to an invalid entry is ignored. Duplicate ports naming the same entry are harmless.
- Commit: lane i asserts commit_valid when all of the following hold:
  - state is RUN and commit_stall=0;
  - i < count;
  - entry head+i has valid & done;
  - all lanes below i are asserted.
  
  Retiring entries are cleared, and head += the number of lanes asserted.
- Flush:
  - flush_req in RUN with entry flush_idx valid: commits proceed normally this cycle. The new tail target is flush_idx+1, in pointer space relative to head.
  - If no entries are younger than flush_idx, state stays RUN.
  - Otherwise the next state is RECOVER.
  - flush_req in RECOVER, or naming an invalid entry, is ignored.
- RECOVER, each cycle:
  - rb_valid=1 for entry tail−1; rb_has_dst and rb_dst come from that entry.
  - The entry is cleared and tail decrements by 1.
  - When tail reaches the target, the next state is RUN.
  - No allocation or commit occurs in RECOVER. Writebacks to surviving entries still set done.
- Simultaneous events: commit and alloc in the same cycle both apply. Writeback and commit of the same entry in the same cycle: the done bit is registered, so that entry commits no earlier than the next cycle.
- Reset mid-RECOVER: everything is dropped and the block returns to its reset state.

## Timing
- Reset values:
  - outputs: alloc_gnt=0, alloc_idx=0, commit_valid=0, commit_idx=0, commit_has_dst=0, commit_dst=0, rb_valid=0, rb_idx=0, rb_has_dst=0, rb_dst=0, count=0, full=0, empty=1, busy=0;
  - state: head=tail=0, all entries invalid.
- alloc_gnt and alloc_idx are combinational in the request cycle. An entry allocated at edge t can take a writeback in cycle t+1.
- A writeback in cycle t allows commit in cycle t+1, at the earliest.
- commit_* is combinational from registered state and commit_stall. Pointers and count update at the next edge.
- Flush in cycle t with N younger entries:
  - rb_valid is high in cycles t+1..t+N, youngest entry first;
  - busy is high in t+1..t+N;
  - allocation is possible again in t+N+1.
- full, empty and count are registered-state derived; they reflect the edge just taken.

## Test plan
- Reset, then alloc_cnt=4 → alloc_gnt=1 with alloc_idx=0,1,2,3; next cycle count=4. A second alloc_cnt=4 → gnt=1 with idx 4..7; count=8, full=1. A third request → alloc_gnt=0.
- Writeback entries 1 then 0 in consecutive cycles → no commit until the cycle after entry 0 completes. Then commit_valid=2'b11 with idx 0,1 and head=2. With commit_stall=1 → commit_valid=0 and head unchanged.
- Wrap: head=6, tail=6, alloc 4 → idx 6,7,0,1. Commit of all four → head wraps to 10 (mod 16), count=0, empty=1.
- Entries 0..5 valid, flush_req with flush_idx=2 → rb_valid for 3 cycles with rb_idx 5,4,3 and matching dst. busy is high for those 3 cycles and alloc_gnt is 0 throughout. Afterwards tail=3, and the next alloc is granted idx 3.
- flush_idx equal to the youngest entry → no RECOVER and busy stays 0. flush_req during RECOVER, or naming an invalid entry → ignored.
- Assert rst_n=0 mid-RECOVER → all outputs return to reset values immediately, and after release alloc_idx restarts at 0.

Source files
------------

// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer sequencing controller.
// Owns head/tail pointers and per-entry status (valid/done/has_dst/dst),
// grants all-or-nothing allocation of up to ISSUE_WIDTH entries per cycle,
// records writeback completion, retires completed entries in order (up to
// COMMIT_WIDTH per cycle) and, after a mispredict, walks squashed entries
// back one per cycle, youngest first, for rename-table rollback.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   alloc_req/cnt/has_dst/dst         rename allocation request (lane-packed)
//   alloc_gnt, alloc_idx              grant and per-lane entry index (comb)
//   wb_valid, wb_idx                  completion ports
//   commit_stall                      commit consumer back-pressure
//   commit_valid/idx/has_dst/dst      in-order retirement lanes (comb)
//   flush_req, flush_idx              mispredict at flush_idx
//   rb_valid/idx/has_dst/dst          one squashed entry per recovery cycle
//   count, full, empty, busy          occupancy and recovery status
module rob_ctrl #(
  parameter  int unsigned ROB_SIZE     = 8,
  parameter  int unsigned ISSUE_WIDTH  = 4,
  parameter  int unsigned COMMIT_WIDTH = 2,
  parameter  int unsigned WB_PORTS     = 2,
  localparam int unsigned IDX_W        = $clog2(ROB_SIZE),
  localparam int unsigned CNT_W        = $clog2(ISSUE_WIDTH + 1),
  localparam int unsigned REG_W        = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_req,
  input  logic [CNT_W-1:0]              alloc_cnt,
  input  logic [ISSUE_WIDTH-1:0]        alloc_has_dst,
  input  logic [ISSUE_WIDTH*REG_W-1:0]  alloc_dst,
  output logic                          alloc_gnt,
  output logic [ISSUE_WIDTH*IDX_W-1:0]  alloc_idx,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]     wb_idx,
  input  logic                          commit_stall,
  output logic [COMMIT_WIDTH-1:0]       commit_valid,
  output logic [COMMIT_WIDTH*IDX_W-1:0] commit_idx,
  output logic [COMMIT_WIDTH-1:0]       commit_has_dst,
  output logic [COMMIT_WIDTH*REG_W-1:0] commit_dst,
  input  logic                          flush_req,
  input  logic [IDX_W-1:0]              flush_idx,
  output logic                          rb_valid,
  output logic [IDX_W-1:0]              rb_idx,
  output logic                          rb_has_dst,
  output logic [REG_W-1:0]              rb_dst,
  output logic [IDX_W:0]                count,
  output logic                          full,
  output logic                          empty,
  output logic                          busy
);

  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic {
    S_RUN     = 1'b0,
    S_RECOVER = 1'b1
  } state_e;

  state_e                              state_q;
  logic [PTR_W-1:0]                    head_q;
  logic [PTR_W-1:0]                    tail_q;
  logic [PTR_W-1:0]                    target_q;
  logic [ROB_SIZE-1:0]                 valid_q;
  logic [ROB_SIZE-1:0]                 done_q;
  logic [ROB_SIZE-1:0]                 has_dst_q;
  logic [ROB_SIZE-1:0][REG_W-1:0]      dst_q;

  logic                                run;
  logic [PTR_W-1:0]                    count_w;
  logic [PTR_W-1:0]                    free_w;
  logic [PTR_W-1:0]                    n_commit;
  logic [IDX_W-1:0]                    flush_off;
  logic [PTR_W-1:0]                    flush_tgt;
  logic                                flush_ok;
  logic                                flush_rec;
  logic [PTR_W-1:0]                    rb_ptr;

  // Occupancy and status, all from registered pointers/state
  assign run     = (state_q == S_RUN);
  assign count_w = tail_q - head_q;
  assign free_w  = PTR_W'(ROB_SIZE) - count_w;
  assign count   = count_w;
  assign full    = (count_w == PTR_W'(ROB_SIZE));
  assign empty   = (count_w == '0);
  assign busy    = (state_q == S_RECOVER);

  // Flush target: one past the mispredicting entry, measured from head
  assign flush_off = flush_idx - head_q[IDX_W-1:0];
  assign flush_tgt = head_q + PTR_W'(flush_off) + PTR_W'(1);
  assign flush_ok  = run && flush_req && valid_q[flush_idx];
  assign flush_rec = flush_ok && (flush_tgt != tail_q);

  // All-or-nothing allocation against the registered free space
  assign alloc_gnt = run && alloc_req && (alloc_cnt != '0) &&
                     (PTR_W'(alloc_cnt) <= free_w) && !flush_req;

  // Per-lane allocation index; zero when nothing is granted
  always_comb begin : alloc_sel
    logic [PTR_W-1:0] ptr;
    ptr       = '0;
    alloc_idx = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      ptr = tail_q + PTR_W'(i);
      if (alloc_gnt) alloc_idx[i*IDX_W +: IDX_W] = ptr[IDX_W-1:0];
    end
  end

  // In-order retirement lanes. While a flush is accepted, lanes past the
  // mispredicting entry are held back so a squashed entry never retires.
  always_comb begin : commit_sel
    logic             chain;
    logic             lane_ok;
    logic [PTR_W-1:0] ptr;
    logic [IDX_W-1:0] slot;
    chain          = run && !commit_stall;
    lane_ok        = 1'b0;
    ptr            = '0;
    slot           = '0;
    n_commit       = '0;
    commit_valid   = '0;
    commit_idx     = '0;
    commit_has_dst = '0;
    commit_dst     = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      ptr     = head_q + PTR_W'(i);
      slot    = ptr[IDX_W-1:0];
      lane_ok = chain && (PTR_W'(i) < count_w) && valid_q[slot] && done_q[slot] &&
                !(flush_ok && (PTR_W'(i) > PTR_W'(flush_off)));
      if (lane_ok) begin
        commit_valid[i]                  = 1'b1;
        commit_idx[i*IDX_W +: IDX_W]     = slot;
        commit_has_dst[i]                = has_dst_q[slot];
        commit_dst[i*REG_W +: REG_W]     = dst_q[slot];
        n_commit                         = n_commit + PTR_W'(1);
      end
      chain = lane_ok;
    end
  end

  // Rollback of the youngest live entry while recovering
  assign rb_ptr     = tail_q - PTR_W'(1);
  assign rb_valid   = busy;
  assign rb_idx     = busy ? rb_ptr[IDX_W-1:0] : '0;
  assign rb_has_dst = busy ? has_dst_q[rb_ptr[IDX_W-1:0]] : 1'b0;
  assign rb_dst     = busy ? dst_q[rb_ptr[IDX_W-1:0]] : '0;

  // State, pointers and entry status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      head_q    <= '0;
      tail_q    <= '0;
      target_q  <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      has_dst_q <= '0;
      dst_q     <= '0;
    end else begin
      // Completion; later clears in this block take priority
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && valid_q[wb_idx[p*IDX_W +: IDX_W]]) begin
          done_q[wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
        end
      end

      case (state_q)
        S_RUN: begin
          for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_valid[i]) begin
              valid_q[commit_idx[i*IDX_W +: IDX_W]] <= 1'b0;
              done_q[commit_idx[i*IDX_W +: IDX_W]]  <= 1'b0;
            end
          end
          head_q <= head_q + n_commit;

          if (alloc_gnt) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
              if (CNT_W'(i) < alloc_cnt) begin
                valid_q[alloc_idx[i*IDX_W +: IDX_W]]   <= 1'b1;
                done_q[alloc_idx[i*IDX_W +: IDX_W]]    <= 1'b0;
                has_dst_q[alloc_idx[i*IDX_W +: IDX_W]] <= alloc_has_dst[i];
                dst_q[alloc_idx[i*IDX_W +: IDX_W]]     <= alloc_dst[i*REG_W +: REG_W];
              end
            end
            tail_q <= tail_q + PTR_W'(alloc_cnt);
          end

          if (flush_rec) begin
            state_q  <= S_RECOVER;
            target_q <= flush_tgt;
          end
        end
        S_RECOVER: begin
          valid_q[rb_ptr[IDX_W-1:0]] <= 1'b0;
          done_q[rb_ptr[IDX_W-1:0]]  <= 1'b0;
          tail_q                     <= rb_ptr;
          if (rb_ptr == target_q) state_q <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl. Allocations push expected retirement records
// onto a scoreboard queue; flushes move the squashed tail of that queue onto
// a rollback queue. A negedge monitor pops and compares whenever the DUT
// retires or rolls back an entry.
module tb_rob_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_req;
  logic [2:0]  alloc_cnt;
  logic [3:0]  alloc_has_dst;
  logic [19:0] alloc_dst;
  logic        alloc_gnt;
  logic [11:0] alloc_idx;
  logic [1:0]  wb_valid;
  logic [5:0]  wb_idx;
  logic        commit_stall;
  logic [1:0]  commit_valid;
  logic [5:0]  commit_idx;
  logic [1:0]  commit_has_dst;
  logic [9:0]  commit_dst;
  logic        flush_req;
  logic [2:0]  flush_idx;
  logic        rb_valid;
  logic [2:0]  rb_idx;
  logic        rb_has_dst;
  logic [4:0]  rb_dst;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        busy;

  rob_ctrl #(.ROB_SIZE(8), .ISSUE_WIDTH(4), .COMMIT_WIDTH(2), .WB_PORTS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_cnt(alloc_cnt), .alloc_has_dst(alloc_has_dst),
    .alloc_dst(alloc_dst), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .commit_stall(commit_stall),
    .commit_valid(commit_valid), .commit_idx(commit_idx),
    .commit_has_dst(commit_has_dst), .commit_dst(commit_dst),
    .flush_req(flush_req), .flush_idx(flush_idx),
    .rb_valid(rb_valid), .rb_idx(rb_idx), .rb_has_dst(rb_has_dst), .rb_dst(rb_dst),
    .count(count), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic       has;
    logic [4:0] dst;
  } exp_t;

  exp_t       cq[$];
  exp_t       rbq[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] tb_head = '0;
  logic [3:0] tb_tail = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    alloc_req     = 1'b0;
    alloc_cnt     = '0;
    alloc_has_dst = '0;
    alloc_dst     = '0;
    wb_valid      = '0;
    wb_idx        = '0;
    commit_stall  = 1'b0;
    flush_req     = 1'b0;
    flush_idx     = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_alloc_gnt"}, 32'(alloc_gnt), 0);
    chk({pfx, "_alloc_idx"}, 32'(alloc_idx), 0);
    chk({pfx, "_commit_valid"}, 32'(commit_valid), 0);
    chk({pfx, "_commit_idx"}, 32'(commit_idx), 0);
    chk({pfx, "_commit_has_dst"}, 32'(commit_has_dst), 0);
    chk({pfx, "_commit_dst"}, 32'(commit_dst), 0);
    chk({pfx, "_rb_valid"}, 32'(rb_valid), 0);
    chk({pfx, "_rb_idx"}, 32'(rb_idx), 0);
    chk({pfx, "_rb_has_dst"}, 32'(rb_has_dst), 0);
    chk({pfx, "_rb_dst"}, 32'(rb_dst), 0);
    chk({pfx, "_count"}, 32'(count), 0);
    chk({pfx, "_full"}, 32'(full), 0);
    chk({pfx, "_empty"}, 32'(empty), 1);
    chk({pfx, "_busy"}, 32'(busy), 0);
  endtask

  // Drive an allocation request and check grant/indices against the model
  task automatic alloc(input int cnt, input logic [3:0] has, input int base);
    logic [3:0]  occ;
    logic [3:0]  p;
    logic [11:0] exp_idx;
    logic        exp_g;
    exp_t        e;
    alloc_req     = 1'b1;
    alloc_cnt     = 3'(cnt);
    alloc_has_dst = has;
    for (int i = 0; i < 4; i++) alloc_dst[i*5 +: 5] = 5'(base + i);
    #1;
    occ     = tb_tail - tb_head;
    exp_g   = (cnt != 0) && (cnt <= 8 - int'(occ));
    exp_idx = '0;
    if (exp_g) begin
      for (int i = 0; i < 4; i++) begin
        p = tb_tail + 4'(i);
        exp_idx[i*3 +: 3] = p[2:0];
      end
    end
    chk("alloc_gnt", 32'(alloc_gnt), 32'(exp_g));
    chk("alloc_idx", 32'(alloc_idx), 32'(exp_idx));
    if (exp_g) begin
      for (int i = 0; i < cnt; i++) begin
        p     = tb_tail + 4'(i);
        e.idx = p[2:0];
        e.has = has[i];
        e.dst = 5'(base + i);
        cq.push_back(e);
      end
      tb_tail = tb_tail + 4'(cnt);
    end
  endtask

  // Complete every outstanding entry, then wait (bounded) for retirement
  task automatic drain();
    exp_t snap[$];
    snap = cq;
    for (int i = 0; i < snap.size(); i += 2) begin
      wb_valid[0]  = 1'b1;
      wb_idx[2:0]  = snap[i].idx;
      if (i + 1 < snap.size()) begin
        wb_valid[1] = 1'b1;
        wb_idx[5:3] = snap[i+1].idx;
      end
      cyc();
    end
    for (int k = 0; k < 16; k++) begin
      if (cq.size() == 0) break;
      cyc();
    end
    chk("drain_done", 32'(cq.size()), 0);
  endtask

  // Model of an accepted flush: squashed records move to the rollback queue
  task automatic model_flush(input logic [2:0] slot, output int n);
    logic [2:0] off;
    logic [3:0] occ;
    logic [3:0] tgt;
    logic [3:0] d;
    off = slot - tb_head[2:0];
    occ = tb_tail - tb_head;
    n   = 0;
    if ({1'b0, off} < occ) begin
      tgt = tb_head + {1'b0, off} + 4'd1;
      d   = tb_tail - tgt;
      n   = int'(d);
      for (int k = 0; k < n; k++) rbq.push_back(cq.pop_back());
      tb_tail = tgt;
    end
  endtask

  task automatic flush_step(input logic [2:0] slot, input bit inject, input logic [2:0] inj_slot);
    int n;
    flush_req = 1'b1;
    flush_idx = slot;
    alloc_req = 1'b1;
    alloc_cnt = 3'd1;
    #1;
    chk("flush_blocks_alloc", 32'(alloc_gnt), 0);
    model_flush(slot, n);
    cyc();
    for (int k = 0; k < n; k++) begin
      alloc_req = 1'b1;
      alloc_cnt = 3'd1;
      if (inject && k == 1) begin
        flush_req = 1'b1;
        flush_idx = inj_slot;
      end
      #1;
      chk("recover_busy", 32'(busy), 1);
      chk("recover_rb_valid", 32'(rb_valid), 1);
      chk("recover_no_alloc", 32'(alloc_gnt), 0);
      cyc();
    end
    #1;
    chk("after_flush_busy", 32'(busy), 0);
    chk("after_flush_rb_valid", 32'(rb_valid), 0);
    chk("rollback_all_seen", 32'(rbq.size()), 0);
  endtask

  // Scoreboard monitor: retirement and rollback records
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (commit_valid[i]) begin
          if (cq.size() == 0) begin
            chk("commit_unexpected", 32'(commit_valid[i]), 0);
          end else begin
            mon_e = cq.pop_front();
            chk("commit_idx", 32'(commit_idx[i*3 +: 3]), 32'(mon_e.idx));
            chk("commit_has_dst", 32'(commit_has_dst[i]), 32'(mon_e.has));
            chk("commit_dst", 32'(commit_dst[i*5 +: 5]), 32'(mon_e.dst));
            tb_head = tb_head + 4'd1;
          end
        end
      end
      if (rb_valid) begin
        if (rbq.size() == 0) begin
          chk("rb_unexpected", 32'(rb_valid), 0);
        end else begin
          mon_e = rbq.pop_front();
          chk("rb_idx", 32'(rb_idx), 32'(mon_e.idx));
          chk("rb_has_dst", 32'(rb_has_dst), 32'(mon_e.has));
          chk("rb_dst", 32'(rb_dst), 32'(mon_e.dst));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    idle();
    rst_n = 1'b0;
    #2;
    chk_reset("reset");
    #15 rst_n = 1'b1;
    cyc();

    // Fill to full, then a refused request
    alloc(4, 4'b1111, 10);
    chk("first_alloc_idx", 32'(alloc_idx), 32'h688);
    cyc();
    chk("count_after_4", 32'(count), 4);
    alloc(4, 4'b0101, 20);
    cyc();
    chk("count_full", 32'(count), 8);
    chk("full_flag", 32'(full), 1);
    chk("not_empty", 32'(empty), 0);
    alloc(1, 4'b0001, 30);
    cyc();

    // Out-of-order completion, in-order retirement
    wb_valid = 2'b01; wb_idx = {3'd0, 3'd1};
    #1 chk("no_commit_wb1", 32'(commit_valid), 0);
    cyc();
    wb_valid = 2'b01; wb_idx = {3'd0, 3'd0};
    #1 chk("no_commit_same_cycle_wb", 32'(commit_valid), 0);
    cyc();
    #1 chk("commit_pair_valid", 32'(commit_valid), 32'h3);
    chk("commit_pair_idx", 32'(commit_idx), 32'b001_000);
    cyc();
    chk("count_after_commit", 32'(count), 6);
    wb_valid = 2'b11; wb_idx = {3'd3, 3'd2};
    cyc();
    commit_stall = 1'b1;
    #1 chk("stall_blocks_commit", 32'(commit_valid), 0);
    cyc();
    commit_stall = 1'b1;
    #1 chk("stall_count_held", 32'(count), 6);
    chk("stall_blocks_commit2", 32'(commit_valid), 0);
    cyc();
    #1 chk("commit_after_stall", 32'(commit_valid), 32'h3);
    chk("commit_after_stall_idx", 32'(commit_idx), 32'b011_010);
    cyc();
    chk("count_after_stall", 32'(count), 4);
    drain();
    chk("empty_count", 32'(count), 0);
    chk("empty_flag", 32'(empty), 1);

    // Walk head to slot 6, then allocate across the index wrap
    alloc(4, 4'b1111, 30);
    cyc();
    alloc(2, 4'b0011, 40);
    cyc();
    drain();
    alloc(4, 4'b1010, 50);
    chk("wrap_alloc_idx", 32'(alloc_idx), 32'h23E);
    cyc();
    drain();
    chk("wrap_count", 32'(count), 0);
    chk("wrap_empty", 32'(empty), 1);

    // Mispredict with three younger entries; a second flush mid-recovery is ignored
    alloc(4, 4'b1111, 60);
    cyc();
    alloc(2, 4'b0001, 64);
    cyc();
    flush_step(3'd4, 1'b1, 3'd2);
    chk("count_after_recover", 32'(count), 3);
    alloc(1, 4'b0001, 70);
    chk("realloc_after_flush", 32'(alloc_idx[2:0]), 5);
    cyc();

    // Flush on the youngest entry, and on an invalid entry: no recovery
    flush_step(3'd5, 1'b0, 3'd0);
    flush_step(3'd7, 1'b0, 3'd0);
    alloc(1, 4'b0000, 71);
    cyc();

    // Reset in the middle of recovery
    flush_req = 1'b1; flush_idx = 3'd2;
    #1 model_flush(3'd2, n);
    chk("big_flush_depth", 32'(n), 4);
    cyc();
    #1 chk("mid_recover_rb", 32'(rb_valid), 1);
    cyc();
    rst_n = 1'b0;
    #1 chk_reset("mid_recover_reset");
    cq.delete();
    rbq.delete();
    tb_head = '0;
    tb_tail = '0;
    #1 rst_n = 1'b1;
    cyc();
    alloc(4, 4'b1111, 80);
    chk("post_reset_alloc_idx", 32'(alloc_idx), 32'h688);
    cyc();
    drain();
    chk("final_empty", 32'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
